// File: rtl/serial_link_peer.sv
// Game Boy link-cable responder: external-clock partner that shifts a byte out on sout
// and captures the console's byte from sin, clocked by the console's sck.
module serial_link_peer #(
    parameter int         TIMEOUT   = 4096,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       sck,
    input  logic       sin,
    output logic       sout,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_armed,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       timeout
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_SHIFT = 1'b1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic        sck_s1, sck_s2, sck_d;
    logic        sin_s1, sin_s2;
    logic [0:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  tx_buf;
    logic [15:0] tmo_cnt;
    logic        sck_rise, sck_fall;
    logic [7:0]  start_byte;

    // Edges come from the synchronised sck against one extra delayed copy.
    assign sck_rise   = sck_s2 & ~sck_d;
    assign sck_fall   = ~sck_s2 & sck_d;
    assign start_byte = tx_armed ? tx_buf : IDLE_BYTE;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_s1   <= 1'b1;
            sck_s2   <= 1'b1;
            sck_d    <= 1'b1;
            sin_s1   <= 1'b1;
            sin_s2   <= 1'b1;
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'hFF;
            tx_buf   <= 8'h00;
            tmo_cnt  <= 16'd0;
            sout     <= 1'b1;
            tx_armed <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            sck_s1   <= sck;
            sck_s2   <= sck_s1;
            sck_d    <= sck_s2;
            sin_s1   <= sin;
            sin_s2   <= sin_s1;
            rx_valid <= 1'b0;
            timeout  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sck_fall) begin
                        shreg    <= start_byte;
                        sout     <= start_byte[7];
                        tx_armed <= 1'b0;
                        bit_cnt  <= 3'd0;
                        tmo_cnt  <= 16'd0;
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        shreg   <= {shreg[6:0], sin_s2};
                        bit_cnt <= bit_cnt + 3'd1;
                        tmo_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {shreg[6:0], sin_s2};
                            rx_valid <= 1'b1;
                            sout     <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end
                    end else if (sck_fall) begin
                        sout    <= shreg[7];
                        tmo_cnt <= 16'd0;
                    end else if (ce) begin
                        if (tmo_cnt == TMO_LAST) begin
                            timeout <= 1'b1;
                            sout    <= 1'b1;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Placed last so a load coinciding with a transfer start keeps the new byte armed.
            if (tx_load) begin
                tx_buf   <= tx_data;
                tx_armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_link_peer.sv
// Directed bench for serial_link_peer: a model console drives sck/sin and checks sout,
// received bytes, pulses and timeout behaviour against hand-computed values.
module tb_serial_link_peer;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce = 1'b0;
    logic       sck;
    logic       sin;
    logic       sout;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_armed;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ce_div = 0;
    int ce_ph = 0;
    int rxv_cnt = 0;
    int tmo_seen = 0;
    int tmo_cyc = 0;
    int last_edge_cyc = 0;

    serial_link_peer #(.TIMEOUT(16), .IDLE_BYTE(8'hFF)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .sck     (sck),
        .sin     (sin),
        .sout    (sout),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .tx_armed(tx_armed),
        .busy    (busy),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .timeout (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // ce pulses once every ce_div cycles; ce_div of 0 holds it low.
    always @(negedge clk_sys) begin
        if (ce_div == 0) begin
            ce = 1'b0;
        end else begin
            ce_ph = (ce_ph + 1) % ce_div;
            ce = (ce_ph == 0);
        end
    end

    always @(negedge clk_sys) begin
        if (rx_valid) rxv_cnt++;
        if (timeout) begin
            tmo_seen++;
            tmo_cyc = cyc;
        end
    end

    task automatic load_byte(input logic [7:0] d);
        @(posedge clk_sys); #1;
        tx_data = d;
        tx_load = 1'b1;
        @(posedge clk_sys); #1;
        tx_load = 1'b0;
    endtask

    // Console clocks bits hi..lo of cb; sout is checked just before each rising edge.
    task automatic clock_bits(input logic [7:0] cb, input logic [7:0] exp, input int hi,
                              input int lo, input int half, input string tag);
        for (int i = hi; i >= lo; i--) begin
            @(posedge clk_sys); #1;
            sck = 1'b0;
            sin = cb[i];
            last_edge_cyc = cyc;
            repeat (half) @(posedge clk_sys);
            #1;
            n_vec++;
            if (sout !== exp[i]) begin
                n_err++;
                $display("[TB] FAIL %s sout bit%0d: got %b expected %b", tag, i, sout, exp[i]);
            end
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL %s busy bit%0d: got %b expected 1", tag, i, busy);
            end
            sck = 1'b1;
            last_edge_cyc = cyc;
            repeat (half - 1) @(posedge clk_sys);
        end
    endtask

    task automatic check_done(input logic [7:0] exp_rx, input int exp_rxv, input string tag);
        repeat (8) @(posedge clk_sys);
        #1;
        n_vec++;
        if (rx_data !== exp_rx) begin
            n_err++;
            $display("[TB] FAIL %s rx_data: got %h expected %h", tag, rx_data, exp_rx);
        end
        n_vec++;
        if (rxv_cnt !== exp_rxv) begin
            n_err++;
            $display("[TB] FAIL %s rx_valid count: got %0d expected %0d", tag, rxv_cnt, exp_rxv);
        end
        n_vec++;
        if (busy !== 1'b0 || sout !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL %s idle busy/sout: got %b/%b expected 0/1", tag, busy, sout);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk_sys);
        #1;
        n_vec++;
        if ({sout, tx_armed, busy, rx_data, rx_valid, timeout} !== {3'b100, 8'h00, 2'b00}) begin
            n_err++;
            $display("[TB] FAIL reset_values: got sout=%b armed=%b busy=%b rx=%h v=%b t=%b expected 1 0 0 00 0 0",
                     sout, tx_armed, busy, rx_data, rx_valid, timeout);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk_sys);
    endtask

    task automatic test_basic;
        int rxv0;
        rxv0 = rxv_cnt;
        load_byte(8'hA5);
        n_vec++;
        if (tx_armed !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL basic armed_before: got %b expected 1", tx_armed);
        end
        clock_bits(8'h3C, 8'hA5, 7, 7, 64, "basic");
        n_vec++;
        if (tx_armed !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic armed_after_fall: got %b expected 0", tx_armed);
        end
        clock_bits(8'h3C, 8'hA5, 6, 0, 64, "basic");
        check_done(8'h3C, rxv0 + 1, "basic");
    endtask

    task automatic test_idle_byte;
        int rxv0;
        rxv0 = rxv_cnt;
        clock_bits(8'h81, 8'hFF, 7, 0, 64, "idle_byte");
        check_done(8'h81, rxv0 + 1, "idle_byte");
    endtask

    task automatic test_timeout;
        int rxv0, tmo0;
        rxv0 = rxv_cnt;
        tmo0 = tmo_seen;
        load_byte(8'h5A);
        ce_div = 1;
        clock_bits(8'hE0, 8'h5A, 7, 5, 8, "timeout");
        repeat (40) @(posedge clk_sys);
        #1;
        n_vec++;
        if (tmo_seen !== tmo0 + 1) begin
            n_err++;
            $display("[TB] FAIL timeout pulse_count: got %0d expected %0d", tmo_seen, tmo0 + 1);
        end
        n_vec++;
        if (tmo_cyc - last_edge_cyc !== 19) begin
            n_err++;
            $display("[TB] FAIL timeout pulse_delay: got %0d expected 19", tmo_cyc - last_edge_cyc);
        end
        check_done(8'h81, rxv0, "timeout_abort");
        ce_div = 8;
        clock_bits(8'h42, 8'hFF, 7, 0, 64, "after_timeout");
        check_done(8'h42, rxv0 + 1, "after_timeout");
    endtask

    task automatic test_mid_load;
        int rxv0;
        rxv0 = rxv_cnt;
        load_byte(8'h22);
        clock_bits(8'h6B, 8'h22, 7, 4, 64, "mid_load");
        load_byte(8'h11);
        clock_bits(8'h6B, 8'h22, 3, 0, 64, "mid_load");
        check_done(8'h6B, rxv0 + 1, "mid_load");
        n_vec++;
        if (tx_armed !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL mid_load armed: got %b expected 1", tx_armed);
        end
        clock_bits(8'h0F, 8'h11, 7, 0, 64, "mid_load_next");
        check_done(8'h0F, rxv0 + 2, "mid_load_next");
    endtask

    task automatic test_load_at_start;
        int rxv0;
        rxv0 = rxv_cnt;
        load_byte(8'h77);
        @(posedge clk_sys); #1;
        sck = 1'b0;
        sin = 1'b1;
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        tx_data = 8'h99;
        tx_load = 1'b1;
        @(posedge clk_sys); #1;
        tx_load = 1'b0;
        repeat (61) @(posedge clk_sys);
        #1;
        n_vec++;
        if (sout !== 1'b0 || tx_armed !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL load_at_start sout/armed: got %b/%b expected 0/1", sout, tx_armed);
        end
        sck = 1'b1;
        repeat (63) @(posedge clk_sys);
        clock_bits(8'hB4, 8'h77, 6, 0, 64, "load_at_start");
        check_done(8'hB4, rxv0 + 1, "load_at_start");
        clock_bits(8'h2D, 8'h99, 7, 0, 64, "load_at_start_next");
        check_done(8'h2D, rxv0 + 2, "load_at_start_next");
    endtask

    task automatic test_reset_mid;
        int rxv0, tmo0;
        rxv0 = rxv_cnt;
        tmo0 = tmo_seen;
        clock_bits(8'h5E, 8'hFF, 7, 4, 64, "reset_mid");
        load_byte(8'hEE);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({sout, busy, tx_armed, rx_data} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("[TB] FAIL reset_mid values: got sout=%b busy=%b armed=%b rx=%h expected 1 0 0 00",
                     sout, busy, tx_armed, rx_data);
        end
        repeat (5) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1;
        n_vec++;
        if (rxv_cnt !== rxv0 || tmo_seen !== tmo0) begin
            n_err++;
            $display("[TB] FAIL reset_mid pulses: got rxv=%0d tmo=%0d expected %0d %0d",
                     rxv_cnt, tmo_seen, rxv0, tmo0);
        end
        clock_bits(8'hC3, 8'hFF, 7, 0, 64, "reset_mid_next");
        check_done(8'hC3, rxv0 + 1, "reset_mid_next");
    endtask

    task automatic test_back_to_back;
        int rxv0, tmo0;
        rxv0 = rxv_cnt;
        tmo0 = tmo_seen;
        load_byte(8'h96);
        clock_bits(8'hA1, 8'h96, 7, 0, 64, "b2b_first");
        #1;
        n_vec++;
        if (rx_data !== 8'hA1) begin
            n_err++;
            $display("[TB] FAIL b2b_first rx_data: got %h expected a1", rx_data);
        end
        clock_bits(8'h5C, 8'hFF, 7, 0, 64, "b2b_second");
        check_done(8'h5C, rxv0 + 2, "b2b_second");
        n_vec++;
        if (tmo_seen !== tmo0) begin
            n_err++;
            $display("[TB] FAIL b2b timeout_count: got %0d expected %0d", tmo_seen, tmo0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sck     = 1'b1;
        sin     = 1'b1;
        tx_data = 8'h00;
        tx_load = 1'b0;
        ce_div  = 8;
        $display("[TB] serial_link_peer directed bench start");
        test_reset();
        test_basic();
        test_idle_byte();
        test_timeout();
        test_mid_load();
        test_load_at_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
